vend_controller: RTL and testbench

Vending sequencer fed by the coin detector's one-cycle dimeDetected/nickelDetected/quarterDetected pulses. It accumulates credit, services product select and cancel requests, and issues a single vend pulse. It then returns change one coin at a time to the coin ejector using a valid/ack handshake. It sits between the coin detector and the product/ejector mechanics.

---
 rtl/vend_controller.sv | 153 +++++++++++++++
 tb/tb_vend_controller.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/vend_controller.sv
// Coin-operated vending sequencer: accumulates credit from the coin detector's pulses,
// releases one product per select, and pays change back one coin at a time over valid/ack.
module vend_controller #(
    parameter int PRICE      = 35,
    parameter int MAX_CREDIT = 200,
    parameter int CREDIT_W   = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                dimeDetected,
    input  logic                nickelDetected,
    input  logic                quarterDetected,
    input  logic                select,
    input  logic                cancel,
    input  logic                ejectAck,
    output logic [CREDIT_W-1:0] credit,
    output logic                vend,
    output logic                insufficient,
    output logic                rejectCoin,
    output logic                ejectValid,
    output logic [1:0]          ejectCoin,
    output logic                busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CREDIT,
        S_VEND,
        S_CHANGE
    } state_t;

    localparam logic [1:0] COIN_NICKEL  = 2'd0;
    localparam logic [1:0] COIN_DIME    = 2'd1;
    localparam logic [1:0] COIN_QUARTER = 2'd2;

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W:0]   MAX_C   = (CREDIT_W+1)'(MAX_CREDIT);

    function automatic logic [CREDIT_W-1:0] coin_cents(input logic [1:0] code);
        case (code)
            COIN_QUARTER: return CREDIT_W'(25);
            COIN_DIME:    return CREDIT_W'(10);
            default:      return CREDIT_W'(5);
        endcase
    endfunction

    // Largest coin that still fits in the remaining amount.
    function automatic logic [1:0] greedy_coin(input logic [CREDIT_W-1:0] amount);
        if (amount >= CREDIT_W'(25)) return COIN_QUARTER;
        if (amount >= CREDIT_W'(10)) return COIN_DIME;
        return COIN_NICKEL;
    endfunction

    state_t              state, state_d;
    logic [CREDIT_W-1:0] credit_d;
    logic [1:0]          det_count;
    logic                single_coin;
    logic                any_coin;
    logic [CREDIT_W-1:0] det_value;
    logic [CREDIT_W:0]   credit_sum;
    logic                coin_accept;
    logic                vend_d;
    logic                insufficient_d;
    logic                reject_d;
    logic                eject_valid_d;
    logic [1:0]          eject_coin_d;
    logic                busy_d;

    // Coin decode: a multi-hot detect is treated as a bad coin, never summed.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        det_count   = {1'b0, nickelDetected} + {1'b0, dimeDetected} + {1'b0, quarterDetected};
        single_coin = (det_count == 2'd1);
        any_coin    = (det_count != 2'd0);
        det_value   = '0;
        if (quarterDetected)
            det_value = CREDIT_W'(25);
        else if (dimeDetected)
            det_value = CREDIT_W'(10);
        else if (nickelDetected)
            det_value = CREDIT_W'(5);
        credit_sum  = {1'b0, credit} + {1'b0, det_value};
        coin_accept = single_coin && (credit_sum <= MAX_C) &&
                      (state == S_IDLE || state == S_CREDIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            state        <= S_IDLE;
            credit       <= '0;
            vend         <= 1'b0;
            insufficient <= 1'b0;
            rejectCoin   <= 1'b0;
            ejectValid   <= 1'b0;
            ejectCoin    <= COIN_NICKEL;
            busy         <= 1'b0;
        end else begin
            state        <= state_d;
            credit       <= credit_d;
            vend         <= vend_d;
            insufficient <= insufficient_d;
            rejectCoin   <= reject_d;
            ejectValid   <= eject_valid_d;
            ejectCoin    <= eject_coin_d;
            busy         <= busy_d;
        end
    end

    // Requests in CREDIT are judged on the registered credit; a same-cycle coin still lands.
    always_comb begin
        state_d  = state;
        credit_d = credit;
        if (coin_accept)
            credit_d = credit_sum[CREDIT_W-1:0];
        case (state)
            S_IDLE: begin
                if (coin_accept)
                    state_d = S_CREDIT;
            end
            S_CREDIT: begin
                if (cancel)
                    state_d = S_CHANGE;
                else if (select && credit >= PRICE_C)
                    state_d = S_VEND;
            end
            S_VEND: begin
                credit_d = credit - PRICE_C;
                state_d  = (credit_d != '0) ? S_CHANGE : S_IDLE;
            end
            S_CHANGE: begin
                if (ejectValid && ejectAck) begin
                    credit_d = credit - coin_cents(ejectCoin);
                    if (credit_d == '0)
                        state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are computed from the upcoming state so they register in step with it.
    always_comb begin
        vend_d         = (state_d == S_VEND);
        busy_d         = (state_d == S_VEND) || (state_d == S_CHANGE);
        eject_valid_d  = (state_d == S_CHANGE);
        eject_coin_d   = eject_valid_d ? greedy_coin(credit_d) : COIN_NICKEL;
        insufficient_d = select && ((state == S_IDLE) ||
                                    (state == S_CREDIT && !cancel && credit < PRICE_C));
        reject_d       = any_coin && !coin_accept;
    end

endmodule

// File: tb/tb_vend_controller.sv
// Directed, table-driven bench for vend_controller plus a hand-written async reset sequence.
module tb_vend_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       dimeDetected, nickelDetected, quarterDetected;
    logic       select, cancel, ejectAck;
    logic [7:0] credit;
    logic       vend, insufficient, rejectCoin, ejectValid, busy;
    logic [1:0] ejectCoin;

    always #5 clk = ~clk;

    vend_controller #(.PRICE(35), .MAX_CREDIT(200), .CREDIT_W(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .dimeDetected    (dimeDetected),
        .nickelDetected  (nickelDetected),
        .quarterDetected (quarterDetected),
        .select          (select),
        .cancel          (cancel),
        .ejectAck        (ejectAck),
        .credit          (credit),
        .vend            (vend),
        .insufficient    (insufficient),
        .rejectCoin      (rejectCoin),
        .ejectValid      (ejectValid),
        .ejectCoin       (ejectCoin),
        .busy            (busy)
    );

    typedef struct packed {
        logic n, d, q, sel, can, ack;
    } in_t;

    typedef struct packed {
        logic [7:0] credit;
        logic       vend, ins, rej, ev;
        logic [1:0] ec;
        logic       busy;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] N    = 6'b100000;
    localparam logic [5:0] D    = 6'b010000;
    localparam logic [5:0] Q    = 6'b001000;
    localparam logic [5:0] SEL  = 6'b000100;
    localparam logic [5:0] CAN  = 6'b000010;
    localparam logic [5:0] ACK  = 6'b000001;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    function automatic void add(input logic [5:0] i, input int cr, input logic v, input logic ins,
                                input logic rej, input logic ev, input int ec, input logic b);
        vec_t x;
        x.i = i;
        x.o = {8'(cr), v, ins, rej, ev, 2'(ec), b};
        vecs.push_back(x);
    endfunction

    function automatic out_t sample();
        out_t s;
        s = {credit, vend, insufficient, rejectCoin, ejectValid, ejectCoin, busy};
        return s;
    endfunction

    // ejectCoin only carries meaning while a coin is expected on the port.
    task automatic check(input string name, input out_t got, input out_t exp);
        out_t g;
        g = got;
        if (!exp.ev)
            g.ec = exp.ec;
        total++;
        if (g !== exp) begin
            bad++;
            $display("FAIL %s: got credit=%0d vend=%b ins=%b rej=%b ev=%b ec=%0d busy=%b ; want credit=%0d vend=%b ins=%b rej=%b ev=%b ec=%0d busy=%b",
                     name, got.credit, got.vend, got.ins, got.rej, got.ev, got.ec, got.busy,
                     exp.credit, exp.vend, exp.ins, exp.rej, exp.ev, exp.ec, exp.busy);
        end
    endtask

    task automatic drive(input in_t v);
        nickelDetected  = v.n;
        dimeDetected    = v.d;
        quarterDetected = v.q;
        select          = v.sel;
        cancel          = v.can;
        ejectAck        = v.ack;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        out_t zero;
        zero = '0;

        // Purchase with exact change.
        add(Q,    25, 0, 0, 0, 0, 0, 0);
        add(D,    35, 0, 0, 0, 0, 0, 0);
        add(SEL,  35, 1, 0, 0, 0, 0, 1);
        add(NONE,  0, 0, 0, 0, 0, 0, 0);
        add(NONE,  0, 0, 0, 0, 0, 0, 0);
        // Purchase with 15 cents change: dime then nickel.
        add(Q,    25, 0, 0, 0, 0, 0, 0);
        add(Q,    50, 0, 0, 0, 0, 0, 0);
        add(SEL,  50, 1, 0, 0, 0, 0, 1);
        add(NONE, 15, 0, 0, 0, 1, 1, 1);
        add(ACK,   5, 0, 0, 0, 1, 0, 1);
        add(ACK,   0, 0, 0, 0, 0, 0, 0);
        // Cancel 40 cents with a slow ejector.
        add(Q,    25, 0, 0, 0, 0, 0, 0);
        add(D,    35, 0, 0, 0, 0, 0, 0);
        add(N,    40, 0, 0, 0, 0, 0, 0);
        add(CAN,  40, 0, 0, 0, 1, 2, 1);
        for (int k = 0; k < 3; k++) add(NONE, 40, 0, 0, 0, 1, 2, 1);
        add(ACK,  15, 0, 0, 0, 1, 1, 1);
        for (int k = 0; k < 3; k++) add(NONE, 15, 0, 0, 0, 1, 1, 1);
        add(ACK,   5, 0, 0, 0, 1, 0, 1);
        for (int k = 0; k < 3; k++) add(NONE,  5, 0, 0, 0, 1, 0, 1);
        add(ACK,   0, 0, 0, 0, 0, 0, 0);
        // Insufficient credit, then select+cancel together refunds.
        add(Q,    25, 0, 0, 0, 0, 0, 0);
        add(N,    30, 0, 0, 0, 0, 0, 0);
        add(SEL,  30, 0, 1, 0, 0, 0, 0);
        add(NONE, 30, 0, 0, 0, 0, 0, 0);
        add(SEL | CAN, 30, 0, 0, 0, 1, 2, 1);
        add(ACK,   5, 0, 0, 0, 1, 0, 1);
        add(ACK,   0, 0, 0, 0, 0, 0, 0);
        add(SEL,   0, 0, 1, 0, 0, 0, 0);
        add(CAN,   0, 0, 0, 0, 0, 0, 0);
        // Credit ceiling, multi-hot coin, and coins during change.
        for (int k = 1; k <= 7; k++) add(Q, 25 * k, 0, 0, 0, 0, 0, 0);
        add(D,   185, 0, 0, 0, 0, 0, 0);
        add(N,   190, 0, 0, 0, 0, 0, 0);
        add(Q,   190, 0, 0, 1, 0, 0, 0);
        add(D | N, 190, 0, 0, 1, 0, 0, 0);
        add(D,   200, 0, 0, 0, 0, 0, 0);
        add(N,   200, 0, 0, 1, 0, 0, 0);
        add(CAN, 200, 0, 0, 0, 1, 2, 1);
        add(ACK | D, 175, 0, 0, 1, 1, 2, 1);
        add(ACK | SEL | CAN, 150, 0, 0, 0, 1, 2, 1);
        for (int k = 5; k >= 1; k--) add(ACK, 25 * k, 0, 0, 0, 1, 2, 1);
        add(ACK,   0, 0, 0, 0, 0, 0, 0);

        drive(in_t'(NONE));
        reset = 1'b1;
        #12;
        check("reset_hold", sample(), zero);
        reset = 1'b0;
        step();
        check("after_reset", sample(), zero);

        foreach (vecs[i]) begin
            drive(vecs[i].i);
            step();
            check($sformatf("vec%0d", i), sample(), vecs[i].o);
        end

        // Reset asserted between edges while paying 15 cents change.
        drive(in_t'(Q));   step();
        drive(in_t'(Q));   step();
        drive(in_t'(SEL)); step();
        drive(in_t'(NONE)); step();
        check("pre_reset_change", sample(), out_t'({8'd15, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1}));
        #3 reset = 1'b1;
        #1 check("async_reset", sample(), zero);
        #2 reset = 1'b0;
        step();
        check("post_reset_idle", sample(), zero);
        drive(in_t'(Q)); step();
        check("post_reset_coin", sample(), out_t'({8'd25, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0}));
        drive(in_t'(NONE));
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
